// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding fetch FSM (IDLE/REQ/HOLD) that holds one
// instruction for decode and resolves the next PC (sequential, branch or jump) on accept.
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] RESET_COUNT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [5:0]  op,
    output logic [31:0] pc_plus4,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e      state_r;
    state_e      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_plus4_r;
    logic [31:0] ir_r;
    logic [31:0] fetch_count_r;
    logic        imem_req_r;
    logic        ir_valid_r;
    logic        capture_s;
    logic        accept_s;
    logic [31:0] branch_off_s;
    logic [31:0] next_pc_s;

    // Next-state decode; ack only matters in REQ and ready only in HOLD
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                state_next_s = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    capture_s    = 1'b1;
                    state_next_s = HOLD;
                end else begin
                    state_next_s = REQ;
                end
            end
            HOLD: begin
                if (ir_ready) begin
                    accept_s     = 1'b1;
                    state_next_s = REQ;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Next-PC selection; jump wins over a taken branch, all sums wrap modulo 2^32
    always_comb begin
        branch_off_s = {{14{ir_r[15]}}, ir_r[15:0], 2'b00};
        if (jump) begin
            next_pc_s = {pc_plus4_r[31:28], ir_r[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc_s = pc_plus4_r + branch_off_s;
        end else begin
            next_pc_s = pc_plus4_r;
        end
    end

    // FSM state and handshake outputs, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            imem_req_r <= 1'b0;
            ir_valid_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            imem_req_r <= (state_next_s == REQ);
            ir_valid_r <= (state_next_s == HOLD);
        end
    end

    // Instruction register: loaded only on a completed memory handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r <= 32'h0000_0000;
        end else if (capture_s) begin
            ir_r <= imem_rdata;
        end
    end

    // PC, its +4 companion and the accept counter advance together on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            pc_plus4_r    <= RESET_PC + 32'd4;
            fetch_count_r <= RESET_COUNT;
        end else if (accept_s) begin
            pc_r          <= next_pc_s;
            pc_plus4_r    <= next_pc_s + 32'd4;
            fetch_count_r <= fetch_count_r + 32'd1;
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign ir_valid    = ir_valid_r;
    assign ir          = ir_r;
    assign op          = ir_r[31:26];
    assign pc_plus4    = pc_plus4_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetches push expected requests/instructions,
// a negedge monitor compares whatever the DUT presents against the queue heads.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [5:0]  op;
    logic [31:0] pc_plus4;
    logic        jump;
    logic        branch;
    logic        zero;
    logic [31:0] fetch_count;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .op(op), .pc_plus4(pc_plus4),
        .jump(jump), .branch(branch), .zero(zero), .fetch_count(fetch_count)
    );

    // second instance preset near the top of both PC and counter ranges
    logic        rst_w_n;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_ir;
    logic [5:0]  w_op;
    logic [31:0] w_pp4;
    logic        w_ctl;
    logic [31:0] w_cnt;

    assign w_ack = w_req;

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .RESET_COUNT(32'hFFFF_FFFE)) dut_w (
        .clk(clk), .rst_n(rst_w_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .ir_valid(w_valid), .ir_ready(w_ready), .ir(w_ir), .op(w_op), .pc_plus4(w_pp4),
        .jump(w_ctl), .branch(w_ctl), .zero(w_ctl), .fetch_count(w_cnt)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] cnt;
    } addr_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pp4;
        logic [31:0] cnt;
    } acc_t;

    addr_t       addr_q[$];
    acc_t        acc_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    logic [31:0] w_cnt_tab [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] w_val_tab [5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_addr(input logic [31:0] a, input logic [31:0] c);
        addr_t e;
        e.addr = a;
        e.cnt  = c;
        addr_q.push_back(e);
    endtask

    // monitor: compare any presented request or held instruction with the queue heads
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (imem_req === 1'b1) begin
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: addr %h while none expected", imem_addr);
                end else begin
                    check32("imem_addr", imem_addr, addr_q[0].addr);
                    check32("count_in_req", fetch_count, addr_q[0].cnt);
                    if (imem_ack === 1'b1) void'(addr_q.pop_front());
                end
            end
            if (ir_valid === 1'b1) begin
                if (acc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: ir %h while none expected", ir);
                end else begin
                    check32("ir", ir, acc_q[0].ir);
                    check32("op", {26'd0, op}, {26'd0, acc_q[0].ir[31:26]});
                    check32("pc_plus4", pc_plus4, acc_q[0].pp4);
                    check32("count_in_hold", fetch_count, acc_q[0].cnt);
                    if (ir_ready === 1'b1) void'(acc_q.pop_front());
                end
            end
            check32("req_valid_excl", {31'd0, imem_req & ir_valid}, 32'd0);
        end
    end

    // one fetch: optional ack wait, optional decode stall, then accept with the given resolution
    task automatic serve(input logic [31:0] data, input int ack_dly, input int rdy_dly,
                         input logic j, input logic b, input logic z, input logic [31:0] exp_next);
        int   n;
        acc_t e;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (imem_req !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL req_timeout: imem_req %b expected 1", imem_req);
            return;
        end
        for (int i = 0; i < ack_dly; i++) begin
            imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
            ir_ready = 1'b1; jump = 1'b1; branch = 1'b1; zero = 1'b1;
            @(posedge clk); #1;
        end
        e.ir  = data;
        e.pp4 = exp_pc + 32'd4;
        e.cnt = exp_cnt;
        acc_q.push_back(e);
        imem_ack = 1'b1; imem_rdata = data;
        ir_ready = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        imem_ack = 1'b0; imem_rdata = 32'h0000_0000;
        for (int i = 0; i < rdy_dly; i++) begin
            imem_ack = 1'b1; imem_rdata = ~data;
            ir_ready = 1'b0; jump = 1'b1; branch = 1'b1; zero = 1'b1;
            @(posedge clk); #1;
        end
        imem_ack = 1'b0; imem_rdata = 32'h0000_0000;
        ir_ready = 1'b1; jump = j; branch = b; zero = z;
        @(posedge clk); #1;
        ir_ready = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
        exp_pc  = exp_next;
        exp_cnt = exp_cnt + 32'd1;
        push_addr(exp_pc, exp_cnt);
        check32("accept_to_req", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rst_w_n = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; ir_ready = 1'b1;
        jump = 1'b0; branch = 1'b0; zero = 1'b0;
        w_rdata = 32'h0000_0000; w_ready = 1'b1; w_ctl = 1'b0;
        exp_pc = 32'h0000_0000; exp_cnt = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        check32("rst_req", {31'd0, imem_req}, 32'd0);
        check32("rst_valid", {31'd0, ir_valid}, 32'd0);
        check32("rst_ir", ir, 32'h0000_0000);
        check32("rst_op", {26'd0, op}, 32'd0);
        check32("rst_count", fetch_count, 32'h0000_0000);
        check32("rst_addr", imem_addr, 32'h0000_0000);
        imem_ack = 1'b0; imem_rdata = 32'h0000_0000; ir_ready = 1'b0;
        push_addr(32'h0000_0000, 32'h0000_0000);
        rst_n = 1'b1;
        @(negedge clk);
        check32("idle_cycle_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        check32("first_req", {31'd0, imem_req}, 32'd1);

        serve(32'h8C01_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
        serve(32'h0022_1820, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0008);
        serve(32'hAC03_0004, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_000C);
        serve(32'h0810_0000, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0040_0000);
        serve(32'h0800_0010, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
        serve(32'h0800_0040, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
        serve(32'h1000_FFFF, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
        serve(32'h1000_FFFF, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0104);
        serve(32'h1000_FFFF, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0003_FFFC);
        serve(32'h2108_0001, 3, 2, 1'b0, 1'b0, 1'b0, 32'h0004_0000);
        serve(32'h1400_0003, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0004_0010);

        // reset in the middle of a request, with a late ack arriving during reset
        imem_ack = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check32("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check32("mid_rst_valid", {31'd0, ir_valid}, 32'd0);
        check32("mid_rst_ir", ir, 32'h0000_0000);
        check32("mid_rst_count", fetch_count, 32'h0000_0000);
        addr_q.delete();
        acc_q.delete();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check32("late_ack_req", {31'd0, imem_req}, 32'd0);
        check32("late_ack_ir", ir, 32'h0000_0000);
        @(posedge clk); #1;
        imem_ack = 1'b0; imem_rdata = 32'h0000_0000;
        exp_pc = 32'h0000_0000; exp_cnt = 32'h0000_0000;
        push_addr(32'h0000_0000, 32'h0000_0000);
        rst_n = 1'b1;

        serve(32'h2000_0001, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
        serve(32'h1000_FFFD, 0, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        serve(32'h0000_0020, 1, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        @(negedge clk);
        @(posedge clk); #1;

        // preset instance: PC and counter wrap
        rst_w_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check32("wrap_count", w_cnt, w_cnt_tab[k]);
            if ((k % 2) == 0) begin
                check32("wrap_req", {31'd0, w_req}, 32'd1);
                check32("wrap_addr", w_addr, w_val_tab[k]);
            end else begin
                check32("wrap_valid", {31'd0, w_valid}, 32'd1);
                check32("wrap_pp4", w_pp4, w_val_tab[k]);
                check32("wrap_ir", w_ir, 32'h0000_0000);
                check32("wrap_op", {26'd0, w_op}, 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  byte address of the requested instruction, equal to the current PC.
REQ-006 SHALL have port imem_ack  input  1  memory response valid; sampled only while imem_req=1.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-008 SHALL have port ir_valid  output  1  fetched instruction available to decode.
REQ-009 SHALL have port ir_ready  input  1  decode accepts the instruction.
REQ-010 SHALL have port ir  output  32  held instruction word.
REQ-011 SHALL have port op  output  6  ir[31:26], the opcode driven into the control decoder.
REQ-012 SHALL have port pc_plus4  output  32  address of the held instruction plus 4.
REQ-013 SHALL have ports jump, branch, zero  input  1 each  decoder/ALU resolution, sampled only in the accept cycle.
REQ-014 SHALL have port fetch_count  output  32  number of instructions accepted by decode.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, HOLD; one instruction in flight, no prefetch.
REQ-016 IDLE: entered on reset; SHALL move to REQ on the first clock edge after rst_n deasserts.
REQ-017 REQ: imem_req=1, imem_addr=PC held stable; on edge with imem_ack=1 SHALL capture imem_rdata into ir and go to HOLD.
REQ-018 imem_ack in the first REQ cycle SHALL be honoured (zero-wait memory: one REQ cycle per fetch).
REQ-019 HOLD: ir_valid=1, ir/op/pc_plus4 stable until accept; imem_req=0.
REQ-020 Accept = ir_valid & ir_ready; on accept SHALL load next PC, increment fetch_count, go to REQ.
REQ-021 Next PC: jump=1 -> {pc_plus4[31:28], ir[25:0], 2'b00}; else branch&zero -> pc_plus4 + (signext(ir[15:0]) << 2); else pc_plus4.
REQ-022 jump=1 SHALL take priority over branch; jump/branch/zero SHALL be ignored outside the accept cycle.
REQ-023 All PC arithmetic SHALL be 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 without error.
REQ-024 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-025 ir_ready while ir_valid=0 SHALL have no effect; imem_ack while imem_req=0 SHALL be ignored.
REQ-026 Accept-to-next-imem_req latency SHALL be exactly 1 cycle; peak throughput one instruction per 2 cycles.
REQ-027 No output SHALL be X after reset; op SHALL always equal ir[31:26].

Reset
REQ-028 rst_n=0 SHALL immediately force: state=IDLE, PC=RESET_PC, ir=0, fetch_count=0, imem_req=0, ir_valid=0.
REQ-029 Reset during REQ or HOLD SHALL abandon the fetch/held instruction; a late imem_ack SHALL be ignored.
REQ-030 After reset release the first imem_addr SHALL be RESET_PC.

Verification
REQ-031 Reset release, ack immediate, ir_ready=1, no jump/branch -> imem_addr 0,4,8; fetch_count 1,2,3; op tracks imem_rdata[31:26].
REQ-032 ir=32'h0800_0010 (J) at PC 0x00400000, jump=1 on accept -> next imem_addr=0x00000040.
REQ-033 BEQ ir=32'h1000_FFFF at PC 0x100, branch=1 zero=1 -> next addr 0x100; zero=0 -> 0x104; jump=1 branch=1 -> jump target used.
REQ-034 imem_ack delayed 3 cycles, ir_ready low 2 cycles -> imem_addr stable in REQ, ir stable in HOLD, fetch_count increments once.
REQ-035 rst_n pulsed low mid-REQ, ack arrives during reset -> imem_req=0, ir_valid=0, ir=0 during reset; first post-reset addr=RESET_PC.
REQ-036 PC=32'hFFFF_FFFC sequential accept -> next imem_addr=0; fetch_count preset near max wraps to 0.
